calc_ctrl: RTL and testbench

CALC_CTRL -- requirements
Module: calc_ctrl

---
 rtl/calc_ctrl_if.sv | 26 ++
 rtl/calc_ctrl.sv | 127 ++++++++++++
 tb/tb_calc_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_ctrl_if.sv
// Request/result handshake bundle for calc_ctrl.
// The master side is the requesters plus the result consumer.
interface calc_ctrl_if #(
    parameter int alu_width = 12,
    parameter int op_width  = 8
);
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [op_width-1:0]  req_op0;
    logic [op_width-1:0]  req_op1;
    logic                 res_valid;
    logic                 res_ready;
    logic [alu_width-1:0] res_data;
    logic                 res_acted;
    logic                 res_id;

    modport master (
        output req_valid, req_op0, req_op1, res_ready,
        input  req_ready, res_valid, res_data, res_acted, res_id
    );

    modport slave (
        input  req_valid, req_op0, req_op1, res_ready,
        output req_ready, res_valid, res_data, res_acted, res_id
    );
endinterface

// File: rtl/calc_ctrl.sv
// Two-requester round-robin front end that streams an operand serially
// into a calc datapath and holds its result until the consumer takes it.
module calc_ctrl #(
    parameter int alu_width = 12,
    parameter int op_width  = 8,
    parameter int calc_lat  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_ctrl_if.slave           bus,
    output logic                 calc_rst,
    output logic                 calc_1,
    output logic                 calc_in,
    input  logic [alu_width-1:0] agg_out2alu,
    input  logic                 agg_out_acted,
    output logic                 busy
);
    localparam int SW = $clog2(op_width + 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, SHIFT, WAIT, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [op_width-1:0]  sh_q, sh_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [3:0]           wcnt_q, wcnt_d;
    logic                 last_q, last_d;
    logic                 id_q, id_d;
    logic [alu_width-1:0] data_q, data_d;
    logic                 acted_q, acted_d;
    logic [1:0]           ready;
    logic                 win;

    // On a tie the requester not granted last wins.
    always_comb begin
        if (&bus.req_valid) win = ~last_q;
        else                win = bus.req_valid[1];
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        scnt_d    = scnt_q;
        wcnt_d    = wcnt_q;
        last_d    = last_q;
        id_d      = id_q;
        data_d    = data_q;
        acted_d   = acted_q;
        ready     = 2'b00;
        calc_rst  = rst;
        calc_1    = 1'b0;
        calc_in   = 1'b0;
        bus.res_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (win) ready = {bus.req_valid[1], 1'b0};
                    else     ready = {1'b0, bus.req_valid[0]};
                end
                if (|ready) begin
                    sh_d    = win ? bus.req_op1 : bus.req_op0;
                    id_d    = win;
                    last_d  = win;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                calc_rst = 1'b1;
                scnt_d   = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                calc_1  = 1'b1;
                calc_in = sh_q[0];
                sh_d    = sh_q >> 1;
                scnt_d  = scnt_q + SW'(1);
                if (scnt_q == SW'(op_width - 1)) begin
                    wcnt_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wcnt_d = wcnt_q + 4'd1;
                if (wcnt_q == 4'(calc_lat - 1)) begin
                    data_d  = agg_out2alu;
                    acted_d = agg_out_acted;
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset leaves last_q at 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            scnt_q  <= '0;
            wcnt_q  <= '0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            data_q  <= '0;
            acted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            scnt_q  <= scnt_d;
            wcnt_q  <= wcnt_d;
            last_q  <= last_d;
            id_q    <= id_d;
            data_q  <= data_d;
            acted_q <= acted_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.res_data  = data_q;
    assign bus.res_acted = acted_q;
    assign bus.res_id    = id_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: default build plus an op_width=4,
// calc_lat=3 build sharing clock and reset.
module tb_calc_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    calc_ctrl_if #(.alu_width(12), .op_width(8)) b1 ();
    calc_ctrl_if #(.alu_width(12), .op_width(4)) b2 ();

    logic        c1_rst, c1_en, c1_in, busy1, act1;
    logic        c2_rst, c2_en, c2_in, busy2, act2;
    logic [11:0] agg1, agg2;

    calc_ctrl #(.alu_width(12), .op_width(8), .calc_lat(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave),
        .calc_rst(c1_rst), .calc_1(c1_en), .calc_in(c1_in),
        .agg_out2alu(agg1), .agg_out_acted(act1), .busy(busy1)
    );

    calc_ctrl #(.alu_width(12), .op_width(4), .calc_lat(3)) u2 (
        .clk(clk), .rst(rst), .bus(b2.slave),
        .calc_rst(c2_rst), .calc_1(c2_en), .calc_in(c2_in),
        .agg_out2alu(agg2), .agg_out_acted(act2), .busy(busy2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int gid  [8];
    int gcyc [8];
    int ones [8];
    int idl  [8];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until the n-th grant is seen on u1; job i stats cover the
    // cycles after grant i up to and including grant i+1.
    task automatic run_jobs(input int n);
        int cur;
        int cyc;
        cur = -1;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            gid[i] = 0; gcyc[i] = 0; ones[i] = 0; idl[i] = 0;
        end
        forever begin
            if (b1.req_ready != 2'b00) begin
                if (cur >= 0) idl[cur]++;
                cur++;
                gid[cur]  = int'(b1.req_ready[1]);
                gcyc[cur] = cyc;
            end else if (cur >= 0) begin
                if (!busy1) idl[cur]++;
                if (c1_en && c1_in) ones[cur]++;
            end
            if (cur == n - 1 || cyc == 300) break;
            tick();
            cyc++;
        end
        chk("jobs_seen", cur + 1, n);
    endtask

    logic [7:0] pat;
    logic [3:0] pat4;
    int         vcnt;

    initial begin
        b1.req_valid = 2'b11; b1.req_op0 = '0; b1.req_op1 = '0;
        b1.res_ready = 1'b0;
        b2.req_valid = 2'b00; b2.req_op0 = '0; b2.req_op1 = '0;
        b2.res_ready = 1'b1;
        agg1 = '0; act1 = 1'b0; agg2 = '0; act2 = 1'b0;

        // reset values with requests pending
        repeat (3) tick();
        chk("rst_req_ready", b1.req_ready, 2'b00);
        chk("rst_calc_rst", c1_rst, 1'b1);
        chk("rst_calc_1", c1_en, 1'b0);
        chk("rst_calc_in", c1_in, 1'b0);
        chk("rst_res_valid", b1.res_valid, 1'b0);
        chk("rst_res_data", b1.res_data, 12'h000);
        chk("rst_res_acted", b1.res_acted, 1'b0);
        chk("rst_res_id", b1.res_id, 1'b0);
        chk("rst_busy", busy1, 1'b0);

        // single job, grant in first cycle after release
        b1.req_valid = 2'b01; b1.req_op0 = 8'hA5; rst = 1'b0;
        #1;
        chk("job1_ready", b1.req_ready, 2'b01);
        tick();
        b1.req_valid = 2'b00;
        #1;
        chk("job1_clear_rst", c1_rst, 1'b1);
        chk("job1_clear_en", c1_en, 1'b0);
        chk("job1_clear_ready", b1.req_ready, 2'b00);
        chk("job1_busy", busy1, 1'b1);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("job1_shift_en", c1_en, 1'b1);
            chk("job1_shift_bit", c1_in, pat[i]);
            chk("job1_shift_rst", c1_rst, 1'b0);
        end
        tick();
        agg1 = 12'h3C5; act1 = 1'b1;
        chk("job1_wait_en", c1_en, 1'b0);
        chk("job1_wait_valid", b1.res_valid, 1'b0);
        tick();
        chk("job1_valid_k11", b1.res_valid, 1'b1);
        chk("job1_data", b1.res_data, 12'h3C5);
        chk("job1_acted", b1.res_acted, 1'b1);
        chk("job1_id", b1.res_id, 1'b0);

        // backpressure in DONE
        agg1 = 12'h000; act1 = 1'b0; b1.req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", b1.res_valid, 1'b1);
            chk("bp_data", b1.res_data, 12'h3C5);
            chk("bp_ready", b1.req_ready, 2'b00);
            chk("bp_busy", busy1, 1'b1);
        end
        b1.res_ready = 1'b1; b1.req_valid = 2'b00;
        tick();
        chk("bp_idle_busy", busy1, 1'b0);
        chk("bp_idle_valid", b1.res_valid, 1'b0);

        // reset in the fourth SHIFT cycle
        b1.req_valid = 2'b01; b1.req_op0 = 8'h3C;
        #1;
        chk("ab_ready", b1.req_ready, 2'b01);
        tick();
        b1.req_valid = 2'b00;
        repeat (4) tick();
        chk("ab_in_shift", c1_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("ab_calc_rst", c1_rst, 1'b1);
        chk("ab_calc_1", c1_en, 1'b0);
        chk("ab_busy", busy1, 1'b0);
        tick();
        rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (b1.res_valid) vcnt++;
        end
        chk("ab_no_result", vcnt, 0);

        b1.req_valid = 2'b10; b1.req_op1 = 8'h96;
        #1;
        chk("ab2_ready", b1.req_ready, 2'b10);
        tick();
        b1.req_valid = 2'b00;
        pat = 8'h96;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("ab2_shift_en", c1_en, 1'b1);
            chk("ab2_shift_bit", c1_in, pat[i]);
        end
        tick();
        agg1 = 12'h0AB; act1 = 1'b0;
        tick();
        chk("ab2_valid", b1.res_valid, 1'b1);
        chk("ab2_data", b1.res_data, 12'h0AB);
        chk("ab2_acted", b1.res_acted, 1'b0);
        chk("ab2_id", b1.res_id, 1'b1);
        tick();

        // tie from reset, both held valid
        rst = 1'b1;
        tick();
        b1.req_valid = 2'b11; b1.req_op0 = 8'h11; b1.req_op1 = 8'h7E;
        rst = 1'b0;
        #1;
        run_jobs(4);
        chk("tie_g0", gid[0], 0);
        chk("tie_g1", gid[1], 1);
        chk("tie_g2", gid[2], 0);
        chk("tie_g3", gid[3], 1);
        chk("tie_ones0", ones[0], 2);
        chk("tie_ones1", ones[1], 6);
        chk("tie_ones2", ones[2], 2);
        chk("tie_gap", gcyc[1] - gcyc[0], 12);

        // back-to-back, req1 only, all-ones operand
        tick();
        b1.req_valid = 2'b10; b1.req_op1 = 8'hFF;
        #1;
        run_jobs(4);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_id", gid[i], 1);
            chk("b2b_ones", ones[i], 8);
            chk("b2b_idle", idl[i], 1);
            chk("b2b_gap", gcyc[i+1] - gcyc[i], 12);
        end
        tick();
        b1.req_valid = 2'b00;

        // op_width=4, calc_lat=3 build
        b2.req_valid = 2'b01; b2.req_op0 = 4'hB;
        #1;
        chk("p_ready", b2.req_ready, 2'b01);
        tick();
        b2.req_valid = 2'b00;
        chk("p_clear", c2_rst, 1'b1);
        pat4 = 4'hB;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("p_shift_en", c2_en, 1'b1);
            chk("p_shift_bit", c2_in, pat4[i]);
        end
        agg2 = 12'h5A5; act2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("p_wait_en", c2_en, 1'b0);
            chk("p_wait_valid", b2.res_valid, 1'b0);
        end
        tick();
        chk("p_valid_k9", b2.res_valid, 1'b1);
        chk("p_data", b2.res_data, 12'h5A5);
        chk("p_acted", b2.res_acted, 1'b1);
        chk("p_id", b2.res_id, 1'b0);
        tick();
        chk("p_idle", busy2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
